// File: rtl/gat_bram_loader.sv
// gat_bram_loader: turns one host word stream into sequential byte-addressed
// writes for the H data, H node-info and weight BRAMs, in that fixed order.
// Each region raises its load_done level once its final word has been written.
module gat_bram_loader #(
  parameter int TOP_WIDTH        = 32,
  parameter int H_DATA_DEPTH     = 242101,
  parameter int NODE_INFO_DEPTH  = 13264,
  parameter int WEIGHT_DEPTH     = 22928,
  parameter int H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH),
  parameter int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
  parameter int WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [TOP_WIDTH-1:0]        s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [TOP_WIDTH-1:0]        h_data_bram_din,
  output logic                        h_data_bram_ena,
  output logic                        h_data_bram_wea,
  output logic [H_DATA_ADDR_W+1:0]    h_data_bram_addra,
  output logic [TOP_WIDTH-1:0]        h_node_info_bram_din,
  output logic                        h_node_info_bram_ena,
  output logic                        h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W+1:0] h_node_info_bram_addra,
  output logic [TOP_WIDTH-1:0]        wgt_bram_din,
  output logic                        wgt_bram_ena,
  output logic                        wgt_bram_wea,
  output logic [WEIGHT_ADDR_W+1:0]    wgt_bram_addra,
  output logic                        h_data_bram_load_done,
  output logic                        h_node_info_bram_load_done,
  output logic                        wgt_bram_load_done,
  output logic                        busy,
  output logic                        err_last
);

  localparam logic [H_DATA_ADDR_W-1:0]    H_LAST  = H_DATA_ADDR_W'(H_DATA_DEPTH - 1);
  localparam logic [NODE_INFO_ADDR_W-1:0] NI_LAST = NODE_INFO_ADDR_W'(NODE_INFO_DEPTH - 1);
  localparam logic [WEIGHT_ADDR_W-1:0]    W_LAST  = WEIGHT_ADDR_W'(WEIGHT_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_H,
    ST_LOAD_NI,
    ST_LOAD_W,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [H_DATA_ADDR_W-1:0]    h_idx;
  logic [NODE_INFO_ADDR_W-1:0] ni_idx;
  logic [WEIGHT_ADDR_W-1:0]    w_idx;

  logic restart;
  logic accept;
  logic h_acc, ni_acc, w_acc;
  logic h_fin, ni_fin, w_fin;
  logic h_fin_q, ni_fin_q, w_fin_q;
  logic last_err;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, stream handshake and per-region accept/complete decode.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    s_ready    = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    h_acc      = 1'b0;
    ni_acc     = 1'b0;
    w_acc      = 1'b0;
    h_fin      = 1'b0;
    ni_fin     = 1'b0;
    w_fin      = 1'b0;
    last_err   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          restart    = 1'b1;
          state_next = ST_LOAD_H;
        end
      end
      ST_LOAD_H: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        accept  = s_valid;
        h_acc   = s_valid;
        h_fin   = s_valid && (h_idx == H_LAST);
        if (h_fin) state_next = ST_LOAD_NI;
      end
      ST_LOAD_NI: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        accept  = s_valid;
        ni_acc  = s_valid;
        ni_fin  = s_valid && (ni_idx == NI_LAST);
        if (ni_fin) state_next = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        accept  = s_valid;
        w_acc   = s_valid;
        w_fin   = s_valid && (w_idx == W_LAST);
        if (w_fin) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
    // s_last belongs on the final weight word and nowhere else.
    last_err = accept && (w_fin ? !s_last : s_last);
  end

  // Region word indices; each wraps explicitly when its region completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_idx  <= '0;
      ni_idx <= '0;
      w_idx  <= '0;
    end else if (restart) begin
      h_idx  <= '0;
      ni_idx <= '0;
      w_idx  <= '0;
    end else begin
      if (h_acc)  h_idx  <= h_fin  ? '0 : h_idx  + 1'b1;
      if (ni_acc) ni_idx <= ni_fin ? '0 : ni_idx + 1'b1;
      if (w_acc)  w_idx  <= w_fin  ? '0 : w_idx  + 1'b1;
    end
  end

  // Registered BRAM write ports; data/address of idle ports hold their value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_data_bram_din        <= '0;
      h_data_bram_ena        <= 1'b0;
      h_data_bram_wea        <= 1'b0;
      h_data_bram_addra      <= '0;
      h_node_info_bram_din   <= '0;
      h_node_info_bram_ena   <= 1'b0;
      h_node_info_bram_wea   <= 1'b0;
      h_node_info_bram_addra <= '0;
      wgt_bram_din           <= '0;
      wgt_bram_ena           <= 1'b0;
      wgt_bram_wea           <= 1'b0;
      wgt_bram_addra         <= '0;
    end else begin
      h_data_bram_ena      <= h_acc;
      h_data_bram_wea      <= h_acc;
      h_node_info_bram_ena <= ni_acc;
      h_node_info_bram_wea <= ni_acc;
      wgt_bram_ena         <= w_acc;
      wgt_bram_wea         <= w_acc;
      if (h_acc) begin
        h_data_bram_din   <= s_data;
        h_data_bram_addra <= {h_idx, 2'b00};
      end
      if (ni_acc) begin
        h_node_info_bram_din   <= s_data;
        h_node_info_bram_addra <= {ni_idx, 2'b00};
      end
      if (w_acc) begin
        wgt_bram_din   <= s_data;
        wgt_bram_addra <= {w_idx, 2'b00};
      end
    end
  end

  // Done levels trail the final write strobe by one cycle; a restart wins over
  // a completion still in flight so the flags read cleared after start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_fin_q                    <= 1'b0;
      ni_fin_q                   <= 1'b0;
      w_fin_q                    <= 1'b0;
      h_data_bram_load_done      <= 1'b0;
      h_node_info_bram_load_done <= 1'b0;
      wgt_bram_load_done         <= 1'b0;
    end else begin
      h_fin_q  <= h_fin;
      ni_fin_q <= ni_fin;
      w_fin_q  <= w_fin;
      if (restart) begin
        h_data_bram_load_done      <= 1'b0;
        h_node_info_bram_load_done <= 1'b0;
        wgt_bram_load_done         <= 1'b0;
      end else begin
        h_data_bram_load_done      <= h_data_bram_load_done      | h_fin_q;
        h_node_info_bram_load_done <= h_node_info_bram_load_done | ni_fin_q;
        wgt_bram_load_done         <= wgt_bram_load_done         | w_fin_q;
      end
    end
  end

  // Sticky framing error, cleared only by a new sequence or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_last <= 1'b0;
    end else if (restart) begin
      err_last <= 1'b0;
    end else if (last_err) begin
      err_last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gat_bram_loader.sv
// Bench for gat_bram_loader with tiny regions (4/2/3 words). Driver pushes
// expected writes into a queue; a negedge monitor pops and compares them.
module tb_gat_bram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] h_din, ni_din, w_din;
  logic        h_ena, h_wea, ni_ena, ni_wea, w_ena, w_wea;
  logic [3:0]  h_addra;
  logic [2:0]  ni_addra;
  logic [3:0]  w_addra;
  logic        h_done, ni_done, w_done, busy, err_last;

  gat_bram_loader #(
    .TOP_WIDTH(32),
    .H_DATA_DEPTH(4),
    .NODE_INFO_DEPTH(2),
    .WEIGHT_DEPTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .h_data_bram_din(h_din),
    .h_data_bram_ena(h_ena),
    .h_data_bram_wea(h_wea),
    .h_data_bram_addra(h_addra),
    .h_node_info_bram_din(ni_din),
    .h_node_info_bram_ena(ni_ena),
    .h_node_info_bram_wea(ni_wea),
    .h_node_info_bram_addra(ni_addra),
    .wgt_bram_din(w_din),
    .wgt_bram_ena(w_ena),
    .wgt_bram_wea(w_wea),
    .wgt_bram_addra(w_addra),
    .h_data_bram_load_done(h_done),
    .h_node_info_bram_load_done(ni_done),
    .wgt_bram_load_done(w_done),
    .busy(busy),
    .err_last(err_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    int          addr;
    logic [31:0] data;
  } wr_t;

  // Hand-derived write map for words 0x10..0x18: region and byte address.
  localparam int EXP_PORT [9] = '{0, 0, 0, 0, 1, 1, 2, 2, 2};
  localparam int EXP_ADDR [9] = '{0, 4, 8, 12, 0, 4, 0, 4, 8};

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  acc_cyc [9];
  int  h_rise   = -1;
  int  ni_rise  = -1;
  int  w_rise   = -1;
  int  err_rise = -1;
  logic prev_h = 1'b0, prev_ni = 1'b0, prev_w = 1'b0, prev_err = 1'b0;

  logic [155:0] all_outs;
  assign all_outs = {s_ready, h_din, h_ena, h_wea, h_addra, ni_din, ni_ena, ni_wea,
                     ni_addra, w_din, w_ena, w_wea, w_addra, h_done, ni_done,
                     w_done, busy, err_last};

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_write(input int port, input int addr, input logic [31:0] data,
                             input logic wea);
    wr_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_write: port %0d addr %0d data %h, none expected", port, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.port != port || e.addr != addr || e.data != data || wea !== 1'b1) begin
        failures++;
        $display("FAIL write: got port %0d addr %0d data %h wea %b expected port %0d addr %0d data %h wea 1",
                 port, addr, data, wea, e.port, e.addr, e.data);
      end
    end
  endtask

  // Monitor: scoreboard writes, port isolation, and rise times of the levels.
  always @(negedge clk) begin
    if (rst) begin
      prev_h = 1'b0; prev_ni = 1'b0; prev_w = 1'b0; prev_err = 1'b0;
    end else begin
      if (h_ena || ni_ena || w_ena) begin
        chk("port_isolation", int'(h_ena) + int'(ni_ena) + int'(w_ena), 1);
      end
      if (h_ena)  check_write(0, int'(h_addra),  h_din,  h_wea);
      if (ni_ena) check_write(1, int'(ni_addra), ni_din, ni_wea);
      if (w_ena)  check_write(2, int'(w_addra),  w_din,  w_wea);
      if (h_done && !prev_h)     h_rise   = cyc;
      if (ni_done && !prev_ni)   ni_rise  = cyc;
      if (w_done && !prev_w)     w_rise   = cyc;
      if (err_last && !prev_err) err_rise = cyc;
      prev_h = h_done; prev_ni = ni_done; prev_w = w_done; prev_err = err_last;
    end
  end

  task automatic pulse_start();
    h_rise = -1; ni_rise = -1; w_rise = -1; err_rise = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_range(input int first, input int last_i, input int last_word, input bit bp);
    for (int k = first; k <= last_i; k++) begin
      int wait_n;
      if (bp) begin
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(negedge clk);
          s_valid = 1'b0;
          s_last  = 1'b0;
        end
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 32'h10 + k;
      s_last  = (k == last_word);
      wait_n  = 0;
      while (!s_ready && wait_n < 50) begin
        @(negedge clk);
        wait_n++;
      end
      if (!s_ready) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout: word %0d not accepted, s_ready 0 expected 1", k);
      end else begin
        exp_q.push_back('{EXP_PORT[k], EXP_ADDR[k], 32'h10 + k});
        acc_cyc[k] = cyc + 1;
      end
    end
  endtask

  task automatic finish_stream();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("all_done", {h_done, ni_done, w_done}, 3'b111);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", longint'(|all_outs), 0);
    rst = 1'b0;

    // Scenario 1: back-to-back load.
    pulse_start();
    chk("s1_busy_after_start", busy, 1);
    send_range(0, 8, 8, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("s1_busy_in_done", busy, 0);
    chk("s1_ready_in_done", s_ready, 0);
    repeat (3) @(negedge clk);
    chk("s1_queue_drained", exp_q.size(), 0);
    chk("s1_h_done_time", h_rise, acc_cyc[3] + 1);
    chk("s1_ni_done_time", ni_rise, acc_cyc[5] + 1);
    chk("s1_w_done_time", w_rise, acc_cyc[8] + 1);
    chk("s1_err_last", err_last, 0);

    // Scenario 2: random back-pressure.
    pulse_start();
    chk("s2_dones_cleared", {h_done, ni_done, w_done}, 0);
    send_range(0, 8, 8, 1'b1);
    finish_stream();
    chk("s2_err_last", err_last, 0);

    // Scenario 3: early s_last on the final H word.
    pulse_start();
    send_range(0, 8, 3, 1'b0);
    finish_stream();
    chk("s3_err_rise_time", err_rise, acc_cyc[3]);
    chk("s3_err_sticky", err_last, 1);

    // Scenario 4: reset after five accepted words.
    pulse_start();
    chk("s4_err_cleared", err_last, 0);
    send_range(0, 4, 8, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    chk("s4_h_done_before_reset", h_done, 1);
    rst = 1'b1;
    #1;
    chk("s4_reset_outputs_zero", longint'(|all_outs), 0);
    chk("s4_h_done_cleared", h_done, 0);
    chk("s4_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    send_range(0, 8, 8, 1'b0);
    finish_stream();

    // Scenario 5: start while busy is ignored; restart from DONE.
    pulse_start();
    send_range(0, 4, 8, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s5_busy_after_ignored_start", busy, 1);
    chk("s5_h_done_kept", h_done, 1);
    send_range(5, 8, 8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_last  = 1'b0;
      s_data  = 32'hDEAD0000 + i;
      chk("s5_ready_low_in_done", s_ready, 0);
    end
    @(negedge clk);
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h10;
    chk("s5_ready_low_with_start", s_ready, 0);
    @(negedge clk);
    start = 1'b0;
    chk("s5_dones_cleared", {h_done, ni_done, w_done}, 0);
    chk("s5_busy_restart", busy, 1);
    chk("s5_ready_restart", s_ready, 1);
    exp_q.push_back('{0, 0, 32'h10});
    send_range(1, 8, 8, 1'b0);
    finish_stream();
    chk("s5_err_last", err_last, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, test incomplete");
    $fatal(1, "watchdog");
  end

endmodule
